// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and width helpers for the systolic array blocks
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int elem_w(input int w);
      return 2 * w;
   endfunction

   // Never returns zero so a degenerate count still gets a 1-bit register.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - times the compute window, snapshots C and streams it row-major
// Optional accumulator-clear pulse on the first drain cycle under SYSTOLIC_DRAIN_CLR_EN.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int W   = 32,
   parameter int N   = 3,
   parameter int LAT = 3 * N
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start,
   input  logic                           i_en,
   input  logic [elem_w(W)*N*N-1:0]       i_C,
   output logic [elem_w(W)-1:0]           o_data,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic                           o_last,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_acc_clr
);

   localparam int EW = elem_w(W);
   localparam int NN = N * N;
   localparam int IW = idx_w(NN);
   localparam int CW = idx_w(LAT + 1);

   state_t           state_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [EW-1:0]    shadow_q [NN];
   logic [EW-1:0]    o_data_q;
   logic             o_valid_q, o_last_q, o_busy_q, o_done_q;
   logic             capture, xfer, last_idx;

   always_comb begin
      cnt_d    = cnt_q + CW'(1);
      idx_d    = idx_q + IW'(1);
      capture  = (state_q == WAIT) && i_en && (cnt_q == CW'(LAT - 1));
      xfer     = (state_q == DRAIN) && o_valid_q && i_ready;
      last_idx = (idx_q == IW'(NN - 1));
   end

`ifdef SYSTOLIC_DRAIN_CLR_EN
   logic o_acc_clr_q;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         o_last_q  <= 1'b0;
         o_busy_q  <= 1'b0;
         o_done_q  <= 1'b0;
         for (int k = 0; k < NN; k++) shadow_q[k] <= '0;
`ifdef SYSTOLIC_DRAIN_CLR_EN
         o_acc_clr_q <= 1'b0;
`endif
      end else begin
         o_done_q <= 1'b0;
`ifdef SYSTOLIC_DRAIN_CLR_EN
         o_acc_clr_q <= capture;
`endif
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  state_q  <= WAIT;
                  cnt_q    <= '0;
                  o_busy_q <= 1'b1;
               end
            end
            WAIT: begin
               if (i_en) cnt_q <= cnt_d;
               if (capture) begin
                  for (int k = 0; k < NN; k++) shadow_q[k] <= i_C[EW*k +: EW];
                  idx_q     <= '0;
                  o_data_q  <= i_C[EW-1:0];
                  o_last_q  <= (NN == 1);
                  o_valid_q <= 1'b1;
                  state_q   <= DRAIN;
               end
            end
            DRAIN: begin
               // o_data/o_last only move on a transfer, so they hold under backpressure.
               if (xfer) begin
                  if (last_idx) begin
                     state_q   <= IDLE;
                     o_valid_q <= 1'b0;
                     o_last_q  <= 1'b0;
                     o_data_q  <= '0;
                     o_busy_q  <= 1'b0;
                     o_done_q  <= 1'b1;
                  end else begin
                     idx_q    <= idx_d;
                     o_data_q <= shadow_q[idx_d];
                     o_last_q <= (idx_d == IW'(NN - 1));
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_data  = o_data_q;
   assign o_valid = o_valid_q;
   assign o_last  = o_last_q;
   assign o_busy  = o_busy_q;
   assign o_done  = o_done_q;

`ifdef SYSTOLIC_DRAIN_CLR_EN
   assign o_acc_clr = o_acc_clr_q;
`else
   assign o_acc_clr = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - scoreboard bench for systolic_drain (W=32, N=3, LAT=9)
// Expected o_acc_clr follows SYSTOLIC_DRAIN_CLR_EN.
module tb_systolic_drain;

   localparam int W   = 32;
   localparam int N   = 3;
   localparam int LAT = 9;
   localparam int NN  = N * N;
   localparam int EW  = 2 * W;
`ifdef SYSTOLIC_DRAIN_CLR_EN
   localparam logic EXP_CLR = 1'b1;
`else
   localparam logic EXP_CLR = 1'b0;
`endif

   logic              i_clk = 1'b0;
   logic              i_rst, i_start, i_en, i_ready;
   logic [EW*NN-1:0]  i_C;
   logic [EW-1:0]     o_data;
   logic              o_valid, o_last, o_busy, o_done, o_acc_clr;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [EW-1:0] exp_q [$];

   systolic_drain #(.W(W), .N(N), .LAT(LAT)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (i_start),
      .i_en     (i_en),
      .i_C      (i_C),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_last   (o_last),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_acc_clr(o_acc_clr)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic load_c(input int base);
      for (int k = 0; k < NN; k++) begin
         i_C[EW*k +: EW] = EW'(base + k + 1);
         exp_q.push_back(EW'(base + k + 1));
      end
   endtask

   // Pulses i_start, then counts edges until o_valid rises.
   task automatic wait_valid(input int stall_from, input int stall_len, input int restart_at,
                             output int n);
      n = 0;
      i_start = 1'b1;
      while (!o_valid && n < 100) begin
         i_en = (n >= stall_from && n < stall_from + stall_len) ? 1'b0 : 1'b1;
         step();
         n++;
         i_start = (n == restart_at);
         if (!o_valid) begin
            total_cnt++;
            if (o_busy !== 1'b1 || o_acc_clr !== 1'b0)
               $display("FAIL wait_state n=%0d busy=%b acc_clr=%b required busy=1 acc_clr=0",
                        n, o_busy, o_acc_clr);
            else pass_cnt++;
         end
      end
      i_start = 1'b0;
      i_en    = 1'b1;
      if (n >= 100) begin
         total_cnt++;
         $display("FAIL wait_timeout o_valid never rose within 100 cycles");
      end
   endtask

   task automatic drain(input int bp, input int stop_after, input bit start_mid, input bit chain,
                        output int nx);
      int            cyc;
      bit            prev_stall, pulsed;
      logic [EW-1:0] prev_data, exp;
      logic          prev_last;
      nx = 0; cyc = 0; prev_stall = 0; pulsed = 0;
      i_C = '1;
      while (nx < stop_after && cyc < 200) begin
         i_ready = (bp != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (start_mid && nx == 4 && !pulsed) begin
            i_start = 1'b1;
            pulsed  = 1;
         end
         total_cnt++;
         if (o_valid !== 1'b1 || o_busy !== 1'b1)
            $display("FAIL drain_valid cyc=%0d valid=%b busy=%b required 1,1", cyc, o_valid, o_busy);
         else pass_cnt++;
         total_cnt++;
         if (o_acc_clr !== ((cyc == 0) ? EXP_CLR : 1'b0))
            $display("FAIL acc_clr cyc=%0d got %b required %b", cyc, o_acc_clr,
                     (cyc == 0) ? EXP_CLR : 1'b0);
         else pass_cnt++;
         if (prev_stall) begin
            total_cnt++;
            if (o_data !== prev_data || o_last !== prev_last)
               $display("FAIL hold_stable cyc=%0d data=%0h last=%b required %0h %b",
                        cyc, o_data, o_last, prev_data, prev_last);
            else pass_cnt++;
         end
         if (o_valid && i_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total_cnt++;
            if (o_data !== exp)
               $display("FAIL data elem=%0d got %0h required %0h", nx, o_data, exp);
            else pass_cnt++;
            total_cnt++;
            if (o_last !== (nx == NN - 1))
               $display("FAIL last elem=%0d got %b required %b", nx, o_last, nx == NN - 1);
            else pass_cnt++;
            nx++;
         end
         prev_stall = o_valid && !i_ready;
         prev_data  = o_data;
         prev_last  = o_last;
         step();
         cyc++;
         i_start = 1'b0;
      end
      i_ready = 1'b1;
      if (cyc >= 200) begin
         total_cnt++;
         $display("FAIL drain_timeout transfers=%0d required %0d", nx, stop_after);
      end
      if (stop_after == NN) begin
         total_cnt++;
         if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL done_pulse done=%b valid=%b busy=%b required 1,0,0", o_done, o_valid, o_busy);
         else pass_cnt++;
         total_cnt++;
         if (exp_q.size() != 0)
            $display("FAIL leftover_elems got %0d required 0", exp_q.size());
         else pass_cnt++;
         if (!chain) begin
            step();
            total_cnt++;
            if (o_done !== 1'b0 || o_busy !== 1'b0)
               $display("FAIL done_single done=%b busy=%b required 0,0", o_done, o_busy);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_start = 1'b0; i_en = 1'b1; i_ready = 1'b1; i_C = '0;
      step();
      step();
      total_cnt++;
      if (o_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
          o_acc_clr !== 1'b0 || o_data !== '0)
         $display("FAIL reset_state valid=%b last=%b busy=%b done=%b clr=%b data=%0h required all 0",
                  o_valid, o_last, o_busy, o_done, o_acc_clr, o_data);
      else pass_cnt++;
      i_rst = 1'b0;
      step();
   endtask

   task automatic run_matrix(input string name, input int base, input int stall_len,
                             input int restart_at, input int exp_lat, input int bp,
                             input bit start_mid, input bit chain);
      int n, nx;
      load_c(base);
      wait_valid(3, stall_len, restart_at, n);
      total_cnt++;
      if (n !== exp_lat) $display("FAIL %s_latency got %0d required %0d", name, n, exp_lat);
      else pass_cnt++;
      drain(bp, NN, start_mid, chain, nx);
   endtask

   task automatic test_basic();            run_matrix("basic", 0, 0, -1, 10, 0, 0, 0);   endtask
   task automatic test_backpressure();     run_matrix("bp", 0, 0, -1, 10, 1, 0, 0);      endtask
   task automatic test_enable_stall();     run_matrix("stall", 0, 4, -1, 14, 0, 0, 0);   endtask
   task automatic test_start_while_busy(); run_matrix("busy", 0, 0, 5, 10, 0, 1, 0);     endtask

   task automatic test_back_to_back();
      run_matrix("b2b_a", 40, 0, -1, 10, 0, 0, 1);
      run_matrix("b2b_b", 60, 0, -1, 10, 1, 0, 0);
   endtask

   task automatic test_reset_mid_drain();
      int n, nx, seen;
      load_c(20);
      wait_valid(3, 0, -1, n);
      drain(0, 4, 0, 0, nx);
      i_rst = 1'b1;
      step();
      total_cnt++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_last !== 1'b0)
         $display("FAIL rst_mid valid=%b busy=%b last=%b required 0,0,0", o_valid, o_busy, o_last);
      else pass_cnt++;
      i_rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (o_valid || o_busy) seen++;
      end
      total_cnt++;
      if (seen != 0) $display("FAIL rst_quiet active_cycles got %0d required 0", seen);
      else pass_cnt++;
      exp_q.delete();
      run_matrix("rst_fresh", 100, 0, -1, 10, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_enable_stall();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output-side companion to the systolic array input sequencer; unloads the N×N result matrix C once a multiply completes.
- Times the compute window from a start pulse, snapshots the array's flat C bus into a shadow register, then streams the elements row-major over a valid/ready interface.
- Sits between the systolic array o_C and the downstream consumer (writeback/DMA).

Parameters:
W, 32, operand width; result elements are 2*W bits
N, 3, array dimension; N*N results per matrix
LAT, 3*N, number of enabled cycles from i_start to C stable at i_C

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse; first A/B column is presented to the array this cycle
i_en  in  1  array enable; wait counter advances only when high
i_C  in  2*W*N*N  array results; element k=r*N+c at bits [2W*(k+1)-1 : 2W*k]
o_data  out  2*W  current result element
o_valid  out  1  o_data valid
i_ready  in  1  consumer accepts o_data
o_last  out  1  high with o_valid on element k=N*N-1
o_busy  out  1  high in WAIT or DRAIN
o_done  out  1  one-cycle pulse after the last element is accepted
o_acc_clr  out  1  accumulator clear pulse to the array (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high on i_rst, clock i_clk.
- Reset values: state=IDLE; cnt=0; idx=0; shadow=0; o_valid=0; o_last=0; o_busy=0; o_done=0; o_acc_clr=0; o_data=0.
- Reset mid-operation aborts WAIT or DRAIN immediately. The partial matrix is discarded and nothing is emitted after reset.
- FSM IDLE:
  - i_start=1 → WAIT, cnt<=0.
  - Otherwise hold.
- FSM WAIT:
  - If i_en=1, cnt<=cnt+1.
  - When cnt==LAT-1 and i_en=1: shadow<=i_C, idx<=0, go to DRAIN.
  - If i_en=0, cnt holds and no capture occurs.
- FSM DRAIN:
  - o_valid=1.
  - o_data=shadow[idx], driven from registers by a mux on idx.
  - o_last=(idx==N*N-1).
  - Transfer occurs on o_valid&&i_ready:
    - idx<N*N-1: idx<=idx+1.
    - idx==N*N-1: go to IDLE, o_done<=1 for exactly one cycle.
- Timing and throughput:
  - First o_valid appears the cycle after capture, i.e. LAT+1 enabled cycles after i_start.
  - One element per cycle with i_ready held high; a full drain takes N*N cycles.
- Handshake rules:
  - While o_valid=1 && i_ready=0, o_data and o_last are stable.
  - o_valid never drops without a transfer, except on reset.
- i_start while o_busy=1 is ignored: no restart, no counter change.
- i_start in the same cycle o_done pulses is accepted, since the FSM is in IDLE that cycle.
- i_C is sampled only at the capture edge; changes on i_C during DRAIN do not affect output.
- idx and cnt widths are $clog2(N*N) and $clog2(LAT+1). No wrap occurs: idx resets to 0 on capture, and cnt is cleared on entry to WAIT.

Optional Feature:
- Macro SYSTOLIC_DRAIN_CLR_EN.
- Defined: o_acc_clr=1 for exactly one cycle, the first DRAIN cycle (the cycle after capture). The array can then zero its accumulators and accept the next i_start while this block drains from the shadow register.
- Not defined: o_acc_clr is tied 0; the port remains present so the interface is stable.

Decomposition:
- Shared package systolic_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2)
  - element-width constant expression 2*W
  - index-width helper based on $clog2
- No sub-module: counter, shadow register and output mux stay inline. The existing delay2 and systolic modules are not instantiated here.

Test Plan:
All scenarios use W=32, N=3, LAT=9.
- Basic drain: A=identity, B=[1..9] row-major, i_start with i_en=1, i_ready=1. Require o_valid first high 10 cycles after i_start; o_data sequence 1,2,…,9; o_last only on 9; o_done one cycle after the transfer of 9.
- Backpressure: same data, i_ready toggled 1,0,0,1,… Require each element held stable while i_ready=0, no element skipped or duplicated, exactly 9 transfers.
- Enable stall: hold i_en=0 for 4 cycles in WAIT. Require first o_valid at 14 cycles after i_start and correct values 1..9.
- Start while busy: pulse i_start at cycle 5 of WAIT and again mid-DRAIN. Require timing and sequence unchanged, 9 elements then a single o_done.
- Reset mid-drain: assert i_rst after the 4th transfer. Require o_valid=0, o_busy=0 next cycle, no further data, and a new i_start producing a fresh full 9-element drain.
- Clear feature: with SYSTOLIC_DRAIN_CLR_EN defined, o_acc_clr is a single-cycle pulse coincident with the first o_valid cycle. Without the macro, o_acc_clr stays 0 throughout.
